count_accum_ctrl: RTL and testbench

- Sequencer for the button-driven mod-(LIMIT+1) counter and its running accumulator.
- Debounces a raw push-button and converts each clean press into one count step.
- Adds each new count value into a saturating accumulator.
- Reports pass completion with a done pulse.
- Sits between the board button/start inputs and the display/accumulator datapath.

---
 rtl/count_accum_ctrl.sv | 121 ++++++++++++
 tb/tb_count_accum_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/count_accum_ctrl.sv
// Button-driven mod-(LIMIT+1) counter sequencer with a debounced press input
// and a saturating running accumulator of the count values.
module count_accum_ctrl #(
  parameter int LIMIT = 10,
  parameter int CW    = 4,
  parameter int AW    = 8,
  parameter int DEB   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          clr,
  input  logic          btn,
  output logic [CW-1:0] counter_out,
  output logic [AW-1:0] acc_out,
  output logic          step,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  // state | meaning
  // IDLE  | waiting for start, presses are dropped
  // RUN   | counting presses into the accumulator
  // DONE  | one-cycle completion marker after wrap
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SW = $clog2(DEB + 1);

  logic          r_sync1, r_sync2;
  logic          r_db, r_db_d, r_press;
  logic [SW-1:0] r_stab;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_acc;
  logic          r_step, r_ovf;

  logic [CW-1:0] w_next_cnt;
  logic [AW:0]   w_sum;

  assign w_next_cnt = r_cnt + CW'(1);
  assign w_sum      = {1'b0, r_acc} + (AW+1)'(w_next_cnt);

  // Debouncer runs in every state so presses outside RUN are consumed, not queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
      r_stab  <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      if (r_stab == SW'(DEB)) begin
        r_db   <= r_sync2;
        r_stab <= '0;
      end else if (r_sync2 != r_db) begin
        r_stab <= r_stab + SW'(1);
      end else begin
        r_stab <= '0;
      end
      r_db_d  <= r_db;
      r_press <= r_db & ~r_db_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_step  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_press) begin
            r_step <= 1'b1;
            if (r_cnt == CW'(LIMIT)) begin
              r_cnt   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_cnt <= w_next_cnt;
              if (w_sum[AW]) begin
                r_acc <= '1;
                r_ovf <= 1'b1;
              end else begin
                r_acc <= w_sum[AW-1:0];
              end
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign counter_out = r_cnt;
  assign acc_out     = r_acc;
  assign step        = r_step;
  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_count_accum_ctrl.sv
// Directed bench for count_accum_ctrl: a default instance plus an AW=5
// instance sharing the same stimulus to exercise accumulator saturation.
module tb_count_accum_ctrl;

  localparam int DEB = 4;

  logic       clk, reset, start, clr, btn;
  logic [3:0] counter_out, counter_out5;
  logic [7:0] acc_out;
  logic [4:0] acc_out5;
  logic       step, busy, done, ovf;
  logic       step5, busy5, done5, ovf5;

  int n_checks = 0;
  int n_fail   = 0;

  count_accum_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .clr(clr), .btn(btn),
    .counter_out(counter_out), .acc_out(acc_out), .step(step),
    .busy(busy), .done(done), .ovf(ovf)
  );

  count_accum_ctrl #(.AW(5)) dut5 (
    .clk(clk), .reset(reset), .start(start), .clr(clr), .btn(btn),
    .counter_out(counter_out5), .acc_out(acc_out5), .step(step5),
    .busy(busy5), .done(done5), .ovf(ovf5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clean press: held 3*DEB cycles, released 3*DEB cycles.
  task automatic do_press(output int nstep, output int cnt_at_step,
                          output int ndone, output int done_busy);
    nstep = 0; cnt_at_step = -1; ndone = 0; done_busy = 0;
    for (int ph = 0; ph < 2; ph++) begin
      btn = (ph == 0);
      for (int i = 0; i < 3*DEB; i++) begin
        tick();
        if (step) begin nstep++; cnt_at_step = int'(counter_out); end
        if (done) begin ndone++; if (busy) done_busy++; end
      end
    end
  endtask

  task automatic idle_count_steps(input int cycles, output int nstep);
    nstep = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (step) nstep++;
    end
  endtask

  initial begin
    int ns, cs, nd, db, exp_acc;
    int exp_acc5 [1:10] = '{1, 3, 6, 10, 15, 21, 28, 31, 31, 31};

    reset = 1'b1; start = 1'b0; clr = 1'b0; btn = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_val("rst_counter", counter_out, 0);
    check_val("rst_acc", acc_out, 0);
    check_val("rst_step", step, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ovf", ovf, 0);

    // Full pass of ten presses, then the wrapping eleventh.
    start = 1'b1; tick(); start = 1'b0;
    check_val("start_busy", busy, 1);
    exp_acc = 0;
    for (int i = 1; i <= 10; i++) begin
      do_press(ns, cs, nd, db);
      exp_acc += i;
      check_val($sformatf("p%0d_steps", i), ns, 1);
      check_val($sformatf("p%0d_count", i), cs, i);
      check_val($sformatf("p%0d_acc", i), acc_out, exp_acc);
      check_val($sformatf("p%0d_acc5", i), acc_out5, exp_acc5[i]);
      check_val($sformatf("p%0d_ovf5", i), ovf5, (i >= 8) ? 1 : 0);
    end
    check_val("pass_ovf", ovf, 0);
    do_press(ns, cs, nd, db);
    check_val("wrap_steps", ns, 1);
    check_val("wrap_count", cs, 0);
    check_val("wrap_acc", acc_out, 55);
    check_val("wrap_done_cycles", nd, 1);
    check_val("wrap_done_busy", db, 0);
    check_val("after_done_busy", busy, 0);
    check_val("after_done_acc_hold", acc_out, 55);

    // New pass clears accumulator and sticky overflow.
    start = 1'b1; tick(); start = 1'b0;
    check_val("restart_acc", acc_out, 0);
    check_val("restart_acc5", acc_out5, 0);
    check_val("restart_ovf5", ovf5, 0);
    check_val("restart_busy", busy, 1);

    // Short glitch and a 1-cycle bounce train are rejected.
    btn = 1'b1;
    for (int i = 0; i < DEB-1; i++) tick();
    btn = 1'b0;
    idle_count_steps(3*DEB, ns);
    check_val("glitch_steps", ns, 0);
    ns = 0;
    for (int i = 0; i < 16; i++) begin
      btn = ~btn;
      tick();
      if (step) ns++;
    end
    btn = 1'b0;
    idle_count_steps(3*DEB, cs);
    check_val("bounce_steps", ns + cs, 0);
    check_val("bounce_count", counter_out, 0);

    // Held press lands exactly DEB+4 edges after the first sampling edge.
    btn = 1'b1;
    ns = 0;
    for (int i = 0; i < DEB+4; i++) begin
      tick();
      if (step) ns++;
    end
    check_val("lat_early_steps", ns, 0);
    check_val("lat_early_count", counter_out, 0);
    tick();
    check_val("lat_step", step, 1);
    check_val("lat_count", counter_out, 1);
    btn = 1'b0;
    idle_count_steps(3*DEB, ns);
    check_val("lat_acc", acc_out, 1);

    for (int i = 2; i <= 4; i++) do_press(ns, cs, nd, db);
    check_val("c4_count", counter_out, 4);
    check_val("c4_acc", acc_out, 10);

    start = 1'b1; tick(); start = 1'b0; tick();
    check_val("run_start_busy", busy, 1);
    check_val("run_start_acc", acc_out, 10);
    check_val("run_start_count", counter_out, 4);

    // clr coincident with press wins and discards the press.
    btn = 1'b1;
    for (int i = 0; i < DEB+4; i++) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check_val("clr_step", step, 0);
    check_val("clr_busy", busy, 0);
    check_val("clr_count", counter_out, 0);
    check_val("clr_acc", acc_out, 10);
    btn = 1'b0;
    idle_count_steps(3*DEB, ns);
    check_val("clr_later_steps", ns, 0);

    // Reset mid-pass at count 6 with the button held.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 6; i++) do_press(ns, cs, nd, db);
    check_val("pre_rst_count", counter_out, 6);
    check_val("pre_rst_acc", acc_out, 21);
    btn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1; tick();
    check_val("midrst_counter", counter_out, 0);
    check_val("midrst_acc", acc_out, 0);
    check_val("midrst_step", step, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_ovf", ovf, 0);
    reset = 1'b0;
    idle_count_steps(20, ns);
    check_val("post_rst_held_steps", ns, 0);
    check_val("post_rst_busy", busy, 0);
    btn = 1'b0;
    idle_count_steps(3*DEB, ns);
    start = 1'b1; tick(); start = 1'b0;
    do_press(ns, cs, nd, db);
    check_val("post_rst_press_steps", ns, 1);
    check_val("post_rst_press_count", cs, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
